// File: rtl/mdio_arb_pkg.sv
// Shared types and constants for the MDIO request arbiter and its round-robin picker.
// The DRAIN state only exists when MDIO_ARB_TIMEOUT_EN is defined.
package mdio_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

  localparam logic        OP_RD        = 1'b1;
  localparam logic        OP_WR        = 1'b0;
  localparam logic [15:0] RD_FAIL_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2
`ifdef MDIO_ARB_TIMEOUT_EN
    ,
    S_DRAIN = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/mdio_req_arbiter_if.sv
// Requester-side and controller-side bundle of the MDIO request arbiter.
// master = arbiter view, slave = requesters plus MDIO controller view.
interface mdio_req_arbiter_if #(
  parameter int N_REQ = 3
);
  // Requests are levels: the arbiter latches fields in the cycle it grants and
  // answers with a single-cycle req_ready, later a single-cycle rsp_valid to the
  // same requester. ctrl_exec/ctrl_done are single-cycle pulses, one op in flight.
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_rd;
  logic [5*N_REQ-1:0]  req_reg_addr;
  logic [16*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_rdata;
  logic                rsp_err;
  logic                ctrl_exec;
  logic                ctrl_rh_wl;
  logic [4:0]          ctrl_phy_addr;
  logic [4:0]          ctrl_reg_addr;
  logic [15:0]         ctrl_wr_data;
  logic                ctrl_done;
  logic [15:0]         ctrl_rd_data;
  logic                ctrl_rd_ack;
  logic                arb_busy;

  modport master (
    input  req_valid, req_rd, req_reg_addr, req_wdata,
    input  ctrl_done, ctrl_rd_data, ctrl_rd_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ctrl_exec, ctrl_rh_wl, ctrl_phy_addr, ctrl_reg_addr, ctrl_wr_data,
    output arb_busy
  );

  modport slave (
    output req_valid, req_rd, req_reg_addr, req_wdata,
    output ctrl_done, ctrl_rd_data, ctrl_rd_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ctrl_exec, ctrl_rh_wl, ctrl_phy_addr, ctrl_reg_addr, ctrl_wr_data,
    input  arb_busy
  );

endinterface

// File: rtl/mdio_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// wrapping modulo N. Returns a one-hot grant and its encoded index.
module mdio_rr_pick
  import mdio_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mdio_req_arbiter.sv
// Shares one MDIO controller between N_REQ requesters, round-robin, one op in flight.
// Optional watchdog with DRAIN state is enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_req_arbiter
  import mdio_arb_pkg::*;
#(
  parameter int         N_REQ       = 3,
  parameter logic [4:0] PHY_ADDR    = 5'h04,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  mdio_req_arbiter_if.master bus,
  output arb_state_e         dbg_state_o
);

  if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mdio_req_arbiter: N_REQ must be 2..4 and TIMEOUT_CYC >= 1");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] last_win_q;
  logic [N_REQ-1:0] owner_q;
  logic [N_REQ-1:0] ready_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             exec_q;
  logic             rh_wl_q;
  logic             rsp_err_q;
  logic [4:0]       reg_addr_q;
  logic [15:0]      wr_data_q;
  logic [15:0]      rsp_rdata_q;
`ifdef MDIO_ARB_TIMEOUT_EN
  logic [31:0]      cnt_q;
`endif

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             sel_rd;
  logic [4:0]       sel_addr;
  logic [15:0]      sel_wdata;

  mdio_rr_pick #(.N(N_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_win_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Field mux driven by the one-hot grant so every slice index is a constant.
  always_comb begin
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_rd    = bus.req_rd[i];
        sel_addr  = bus.req_reg_addr[i*5 +: 5];
        sel_wdata = bus.req_wdata[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      last_win_q  <= IDX_W'(N_REQ - 1);
      owner_q     <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      exec_q      <= 1'b0;
      rh_wl_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      rsp_rdata_q <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      ready_q     <= '0;
      rsp_valid_q <= '0;
      exec_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|pick_grant) begin
            ready_q    <= pick_grant;
            owner_q    <= pick_grant;
            exec_q     <= 1'b1;
            last_win_q <= pick_idx;
            rh_wl_q    <= sel_rd;
            reg_addr_q <= sel_addr;
            wr_data_q  <= sel_wdata;
`ifdef MDIO_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ctrl_done) begin
            rsp_valid_q <= owner_q;
            if (rh_wl_q == OP_RD) begin
              rsp_err_q   <= ~bus.ctrl_rd_ack;
              rsp_rdata_q <= bus.ctrl_rd_ack ? bus.ctrl_rd_data : RD_FAIL_DATA;
            end else begin
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
            end
            state_q <= S_RESP;
          end
`ifdef MDIO_ARB_TIMEOUT_EN
          // Give up on the controller; the late done is swallowed in DRAIN.
          else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            rsp_valid_q <= owner_q;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= RD_FAIL_DATA;
            state_q     <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
`endif
        end
        S_RESP: state_q <= S_IDLE;
`ifdef MDIO_ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (bus.ctrl_done) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.ctrl_exec     = exec_q;
  assign bus.ctrl_rh_wl    = rh_wl_q;
  assign bus.ctrl_phy_addr = PHY_ADDR;
  assign bus.ctrl_reg_addr = reg_addr_q;
  assign bus.ctrl_wr_data  = wr_data_q;
  assign bus.arb_busy      = (state_q != S_IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// Self-checking bench for mdio_req_arbiter: directed requests, a latency-programmable
// MDIO controller model, and a monitor that scores grants and responses from queues.
module tb_mdio_req_arbiter;
  import mdio_arb_pkg::*;

  localparam int N = 3;
`ifdef MDIO_ARB_TIMEOUT_EN
  localparam int TO_CYC = 64;
`else
  localparam int TO_CYC = 4096;
`endif
  localparam logic [4:0]  PHY = 5'h04;
  localparam logic [51:0] RESET_OUTS = {3'b0, 3'b0, 16'h0, 1'b0, 1'b0, 1'b0, PHY, 5'h00, 16'h0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  arb_state_e dbg_state;
  int         cyc = 0;

  mdio_req_arbiter_if #(.N_REQ(N)) bus ();

  mdio_req_arbiter #(.N_REQ(N), .PHY_ADDR(PHY), .TIMEOUT_CYC(TO_CYC)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [29:0] exp_cmd_q[$];  // {ready one-hot, rh_wl, phy, reg, wdata}
  logic [19:0] exp_rsp_q[$];  // {rsp one-hot, rdata, err}
  bit  to_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [51:0] outs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.ctrl_exec,
            bus.ctrl_rh_wl, bus.ctrl_phy_addr, bus.ctrl_reg_addr, bus.ctrl_wr_data, bus.arb_busy};
  endfunction

  // ---------------- MDIO controller model ----------------
  int          model_lat = 5;
  logic [15:0] model_data = 16'hA5A0;
  logic        model_ack = 1'b1;
  bit          model_never = 0;
  bit          stray_pulse = 0;
  int          mcnt = 0;

  initial begin
    bit fire;
    bus.ctrl_done    = 1'b0;
    bus.ctrl_rd_data = '0;
    bus.ctrl_rd_ack  = 1'b0;
    forever begin
      @(negedge clk);
      fire = 0;
      bus.ctrl_done = 1'b0;
      if (!rst_n) mcnt = 0;
      else if (mcnt != 0) begin
        mcnt--;
        if (mcnt == 0) fire = 1;
      end else if (bus.ctrl_exec && !model_never) begin
        if (model_lat == 0) fire = 1;
        else mcnt = model_lat;
      end
      if (fire || stray_pulse) begin
        bus.ctrl_done    = 1'b1;
        bus.ctrl_rd_data = model_data;
        bus.ctrl_rd_ack  = model_ack;
        stray_pulse      = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit inflight = 0;
    int exec_cyc = 0;
    int done_cyc = -10;
    logic [29:0] ce;
    logic [19:0] re;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) inflight = 0;
      if (bus.ctrl_exec || (|bus.req_ready)) begin
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_grant", {bus.req_ready, bus.ctrl_exec}, 0);
        end else begin
          ce = exp_cmd_q.pop_front();
          check("grant_cmd", {bus.req_ready, bus.ctrl_rh_wl, bus.ctrl_phy_addr,
                              bus.ctrl_reg_addr, bus.ctrl_wr_data}, ce);
          check("exec_with_ready", bus.ctrl_exec, 1);
          check("one_in_flight", inflight, 0);
        end
        inflight = 1;
        exec_cyc = cyc;
      end
      if (bus.ctrl_done) begin
        done_cyc = cyc;
        inflight = 0;
      end
      if (|bus.rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_valid, 0);
        end else begin
          re = exp_rsp_q.pop_front();
          check("rsp_data", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, re);
          if (to_mode) check("rsp_timeout_delay", cyc - exec_cyc, TO_CYC);
          else         check("rsp_after_done", cyc - done_cyc, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic rd, input logic [4:0] addr, input logic [15:0] wd);
    bus.req_rd[idx]              = rd;
    bus.req_reg_addr[idx*5 +: 5] = addr;
    bus.req_wdata[idx*16 +: 16]  = wd;
    bus.req_valid[idx]           = 1'b1;
  endtask

  // Dropping valid and scrambling fields after the grant must not disturb the op.
  task automatic release_req(input int idx);
    bus.req_valid[idx]           = 1'b0;
    bus.req_rd[idx]              = 1'($urandom_range(0, 1));
    bus.req_reg_addr[idx*5 +: 5] = 5'($urandom_range(0, 31));
    bus.req_wdata[idx*16 +: 16]  = 16'($urandom_range(0, 65535));
  endtask

  task automatic push_cmd(input int idx, input logic rd, input logic [4:0] addr, input logic [15:0] wd);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    exp_cmd_q.push_back({oh, rd, PHY, addr, wd});
  endtask

  task automatic push_rsp(input int idx, input logic [15:0] data, input logic err);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    exp_rsp_q.push_back({oh, data, err});
  endtask

  task automatic wait_ready(input int idx, input int max, output int n);
    n = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      n++;
      if (bus.req_ready[idx]) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (!bus.arb_busy && exp_rsp_q.size() == 0 && exp_cmd_q.size() == 0) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int grants;
    rst_n            = 1'b0;
    bus.req_valid    = '0;
    bus.req_rd       = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", outs(), RESET_OUTS);
    check("reset_state", dbg_state, S_IDLE);

    // Round-robin: all requesters valid out of reset, expect 0,1,2,0,1,2.
    set_req(0, 1'b1, 5'h02, 16'h0000);
    set_req(1, 1'b0, 5'h03, 16'hBEEF);
    set_req(2, 1'b1, 5'h04, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      push_cmd(0, 1'b1, 5'h02, 16'h0000); push_rsp(0, 16'hA5A0, 1'b0);
      push_cmd(1, 1'b0, 5'h03, 16'hBEEF); push_rsp(1, 16'h0000, 1'b0);
      push_cmd(2, 1'b1, 5'h04, 16'h0000); push_rsp(2, 16'hA5A0, 1'b0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    grants = 0;
    for (int c = 0; c < 400 && grants < 6; c++) begin
      @(negedge clk);
      if (|bus.req_ready) grants++;
    end
    bus.req_valid = '0;
    check("rr_grant_count", grants, 6);
    wait_idle(100);

    // Single write, controller takes 100 cycles.
    @(negedge clk);
    model_lat = 100;
    set_req(1, 1'b0, 5'h00, 16'h1140);
    push_cmd(1, 1'b0, 5'h00, 16'h1140); push_rsp(1, 16'h0000, 1'b0);
    wait_ready(1, 10, n);
    check("wr_ready_latency", n, 1);
    release_req(1);
    wait_idle(300);

    // Read with ack.
    model_lat = 7; model_data = 16'h796D; model_ack = 1'b1;
    set_req(0, 1'b1, 5'h01, 16'h0000);
    push_cmd(0, 1'b1, 5'h01, 16'h0000); push_rsp(0, 16'h796D, 1'b0);
    wait_ready(0, 10, n);
    release_req(0);
    wait_idle(100);

    // Read without ack: data forced to all ones, err set.
    model_lat = 9; model_data = 16'h1234; model_ack = 1'b0;
    set_req(2, 1'b1, 5'h1F, 16'h0000);
    push_cmd(2, 1'b1, 5'h1F, 16'h0000); push_rsp(2, 16'hFFFF, 1'b1);
    wait_ready(2, 10, n);
    release_req(2);
    wait_idle(100);

    // Done in the same cycle as exec.
    model_lat = 0; model_ack = 1'b1;
    set_req(0, 1'b0, 5'h10, 16'hFFFF);
    push_cmd(0, 1'b0, 5'h10, 16'hFFFF); push_rsp(0, 16'h0000, 1'b0);
    wait_ready(0, 10, n);
    release_req(0);
    wait_idle(50);

    // Stray done while idle is ignored.
    stray_pulse = 1;
    repeat (5) @(negedge clk);
    check("stray_done_busy", bus.arb_busy, 0);
    check("stray_done_state", dbg_state, S_IDLE);

    // Reset during WAIT of a read from requester 1.
    model_lat = 60; model_data = 16'h0BAD;
    set_req(1, 1'b1, 5'h07, 16'h0000);
    push_cmd(1, 1'b1, 5'h07, 16'h0000);
    wait_ready(1, 10, n);
    release_req(1);
    repeat (10) @(negedge clk);
    set_req(0, 1'b1, 5'h08, 16'h0000);
    set_req(2, 1'b0, 5'h09, 16'h00C3);
    check("busy_mid_wait", bus.arb_busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", outs(), RESET_OUTS);
    check("reset_async_state", dbg_state, S_IDLE);
    repeat (3) @(negedge clk);
    model_lat = 4; model_data = 16'h4321;
    push_cmd(0, 1'b1, 5'h08, 16'h0000); push_rsp(0, 16'h4321, 1'b0);
    push_cmd(2, 1'b0, 5'h09, 16'h00C3); push_rsp(2, 16'h0000, 1'b0);
    rst_n = 1'b1;
    wait_ready(0, 10, n);
    check("first_after_reset_latency", n, 1);
    release_req(0);
    wait_ready(2, 40, n);
    release_req(2);
    wait_idle(100);

`ifdef MDIO_ARB_TIMEOUT_EN
    // Controller never answers: timeout response, then DRAIN until the late done.
    model_never = 1;
    set_req(0, 1'b1, 5'h02, 16'h0000);
    push_cmd(0, 1'b1, 5'h02, 16'h0000); push_rsp(0, 16'hFFFF, 1'b1);
    to_mode = 1;
    wait_ready(0, 10, n);
    release_req(0);
    set_req(1, 1'b0, 5'h03, 16'h0042);
    for (int c = 0; c < 200 && exp_rsp_q.size() != 0; c++) @(negedge clk);
    check("timeout_rsp_seen", exp_rsp_q.size(), 0);
    repeat (20) @(negedge clk);
    to_mode = 0;
    check("drain_busy", bus.arb_busy, 1);
    check("drain_state", dbg_state, S_DRAIN);
    push_cmd(1, 1'b0, 5'h03, 16'h0042); push_rsp(1, 16'h0000, 1'b0);
    model_never = 0; model_lat = 3;
    stray_pulse = 1;
    wait_ready(1, 10, n);
    release_req(1);
    wait_idle(50);
`endif

    repeat (5) @(negedge clk);
    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    check("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_req_arbiter.md
Name: mdio_req_arbiter

Overview:
- Shares one MDIO master controller (exec/done op interface driving eth_mdc/eth_mdio) between N_REQ independent requesters, e.g. a PHY config sequencer, link-status poller and debug/key-triggered access.
- Round-robin grant, one MDIO transaction in flight at a time.
- Per-requester response with read data and error flag.
- Sits between the requester logic and the MDIO controller, in the sys_clk domain.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- PHY_ADDR, 5'h04, PHY address forwarded on every transaction.
- TIMEOUT_CYC, 4096, sys_clk cycles allowed from ctrl_exec to ctrl_done (used only with the optional feature).

Ports:
- sys_clk  in  1  single clock; every flop is clocked by it.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester transaction request, level.
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- req_rd  in  N_REQ  1=read, 0=write, per requester.
- req_reg_addr  in  5*N_REQ  packed PHY register addresses; slice i belongs to requester i.
- req_wdata  in  16*N_REQ  packed write data.
- rsp_valid  out  N_REQ  one-cycle completion pulse to the owner.
- rsp_rdata  out  16  read data, shared, qualified by rsp_valid.
- rsp_err  out  1  error flag, shared, qualified by rsp_valid.
- ctrl_exec  out  1  one-cycle start pulse to the MDIO controller.
- ctrl_rh_wl  out  1  1=read, 0=write.
- ctrl_phy_addr  out  5  equals PHY_ADDR.
- ctrl_reg_addr  out  5  register address.
- ctrl_wr_data  out  16  write data.
- ctrl_done  in  1  controller completion pulse.
- ctrl_rd_data  in  16  controller read data.
- ctrl_rd_ack  in  1  1 = PHY acknowledged the read turnaround.
- arb_busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values:
  - All outputs are 0, except ctrl_phy_addr = PHY_ADDR.
  - last_win = N_REQ-1, so requester 0 has top priority first.
  - State = IDLE.
- States: IDLE, WAIT, RESP, DRAIN (DRAIN exists only with the optional feature).
- IDLE, cycle T with any req_valid set:
  - Winner w = first set bit searching from last_win+1 upward, modulo N_REQ.
  - Latch req_rd[w], req_reg_addr slice w and req_wdata slice w into the ctrl_* registers.
  - last_win <= w; go to WAIT.
  - In cycle T+1, req_ready[w]=1 and ctrl_exec=1, both exactly one cycle.
- Field capture:
  - Fields are captured in cycle T; changes to requester inputs after T have no effect.
  - A requester that drops req_valid before cycle T is not granted. No other accept rule applies.
- WAIT:
  - ctrl_done is accepted in any WAIT cycle, including the ctrl_exec cycle.
  - On ctrl_done in cycle D: latch rdata/err and go to RESP.
- RESP, cycle D+1:
  - rsp_valid[w]=1 for one cycle; go to IDLE.
  - A new grant is evaluated at the earliest in cycle D+2; the earliest next ctrl_exec is D+3.
- Response data:
  - Read: rsp_rdata = ctrl_rd_data and rsp_err = ~ctrl_rd_ack. If rsp_err=1, rsp_rdata = 16'hFFFF.
  - Write: rsp_rdata = 0 and rsp_err = 0.
- ctrl_done outside WAIT (and outside DRAIN when the feature is present) is ignored.
- Simultaneous requests: exactly one winner. A requester that is continuously valid waits at most N_REQ-1 transactions.
- Fairness: the winner's own req_valid may stay high; it is lowest priority in the next round.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with outputs at reset values.
  - No rsp_valid is issued for the aborted transaction.
  - The controller is reset from the same sys_rst_n.

Optional Feature:
- Macro MDIO_ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering WAIT, incremented each WAIT cycle.
  - If the counter reaches TIMEOUT_CYC without ctrl_done:
    - rsp_valid[w]=1 next cycle, with rsp_err=1 and rsp_rdata=16'hFFFF.
    - Then go to DRAIN, arb_busy=1, no grants.
  - DRAIN exits to IDLE on the late ctrl_done, which is discarded.
- Undefined:
  - No counter and no DRAIN state.
  - WAIT waits for ctrl_done indefinitely.

Decomposition:
- Package mdio_arb_pkg contains:
  - the state enum;
  - op encoding constants OP_RD=1'b1 and OP_WR=1'b0;
  - RD_FAIL_DATA = 16'hFFFF;
  - MAX_REQ = 4.
- Sub-module mdio_rr_pick, combinational:
  - Inputs: req vector and last_win.
  - Outputs: one-hot grant and encoded index.
  - It is the natural split and is reused by other round-robin sharers.

Test Plan:
- Single write: req_valid[1] with addr 5'h00 and wdata 16'h1140.
  - Expect req_ready[1] and ctrl_exec in the cycle after the request.
  - Expect ctrl_reg_addr=0, ctrl_wr_data=16'h1140, ctrl_rh_wl=0.
  - The model raises done after 100 cycles; expect rsp_valid[1] one cycle later with err=0.
- Read with ack: req_valid[0] reads reg 5'h01; model returns 16'h796D with ack=1.
  - Expect rsp_rdata=16'h796D and rsp_err=0.
- Read without ack: model returns ack=0 and data 16'h1234.
  - Expect rsp_rdata=16'hFFFF and rsp_err=1.
- Round-robin: all three req_valid held high from reset.
  - Expect grant order 0,1,2,0,1,2.
  - Expect exactly one ctrl_exec per done, never two in flight.
- Timeout (MDIO_ARB_TIMEOUT_EN, TIMEOUT_CYC=64): model never raises done.
  - Expect rsp_valid with err=1 and data 16'hFFFF about 64 cycles after ctrl_exec.
  - Expect no further ctrl_exec until the late done arrives.
- Reset mid-WAIT: drop sys_rst_n for 3 cycles during a read.
  - Expect all outputs at reset values immediately (asynchronously), with no rsp_valid.
  - Expect requester 0 to be granted first after reset.
